crc_frame_serializer: RTL and testbench

Upstream feeder for the bit-serial CRC-8 generator.
- Accepts parallel frame bytes over a valid/ready handshake and serializes them onto a bit stream with backpressure.
- Drives the generator's data_valid/data_bit pair one cycle per accepted bit.
- After the last byte of a frame, reads back the generator's CRC and appends it to the stream, MSB first, marking the final bit with tx_last.

---
 rtl/crc_frame_serializer.sv | 159 +++++++++++++++
 tb/tb_crc_frame_serializer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer: serializes parallel frame words onto a valid/ready bit
// stream, feeds each accepted bit to an external bit-serial CRC generator, and
// appends the generator's CRC (MSB first) at the end of every frame.
module crc_frame_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CRC_W     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              tx_valid,
    output logic              tx_bit,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              crc_clear,
    output logic              crc_data_valid,
    output logic              crc_data_bit,
    input  logic [CRC_W-1:0]  crc_in
);

    localparam int unsigned SR_W  = (DATA_W > CRC_W) ? DATA_W : CRC_W;
    localparam int unsigned CNT_W = (SR_W > 1) ? $clog2(SR_W) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CRC,
        CRC_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              first_q, first_d;

    logic              data_bit;
    logic [SR_W-1:0]   sr_data_shift;

    // Data bit selection and shift direction follow the configured word bit order
    always_comb begin
        if (MSB_FIRST != 0) begin
            data_bit      = sr_q[DATA_W-1];
            sr_data_shift = sr_q << 1;
        end else begin
            data_bit      = sr_q[0];
            sr_data_shift = sr_q >> 1;
        end
    end

    // Next-state and output decode; every output is forced low while reset is high
    always_comb begin
        state_d        = state_q;
        sr_d           = sr_q;
        cnt_d          = cnt_q;
        last_d         = last_q;
        first_d        = first_q;
        in_ready       = 1'b0;
        tx_valid       = 1'b0;
        tx_bit         = 1'b0;
        tx_last        = 1'b0;
        crc_clear      = 1'b0;
        crc_data_valid = 1'b0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        crc_clear = first_q;
                        first_d   = 1'b0;
                        sr_d      = SR_W'(in_data);
                        last_d    = in_last;
                        cnt_d     = '0;
                        state_d   = SHIFT;
                    end
                end

                SHIFT: begin
                    tx_valid       = 1'b1;
                    tx_bit         = data_bit;
                    crc_data_valid = tx_ready;
                    if (tx_ready) begin
                        sr_d  = sr_data_shift;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            if (last_q) begin
                                state_d = WAIT_CRC;
                            end else begin
                                // Refill window: accept the next word on the same
                                // edge the last bit leaves, so the stream has no gap.
                                in_ready = 1'b1;
                                if (in_valid) begin
                                    sr_d   = SR_W'(in_data);
                                    last_d = in_last;
                                    cnt_d  = '0;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                        end
                    end
                end

                WAIT_CRC: begin
                    // Generator registered the final data bit on the previous edge.
                    sr_d    = SR_W'(crc_in);
                    cnt_d   = '0;
                    state_d = CRC_OUT;
                end

                CRC_OUT: begin
                    tx_valid = 1'b1;
                    tx_bit   = sr_q[CRC_W-1];
                    tx_last  = (cnt_q == CRC_LAST);
                    if (tx_ready) begin
                        sr_d  = sr_q << 1;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CRC_LAST) begin
                            state_d = IDLE;
                            first_d = 1'b1;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // Generator always sees exactly the bit presented on the serial output
    always_comb begin
        crc_data_bit = tx_bit;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            first_q <= first_d;
        end
    end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb_crc_frame_serializer: directed bench for crc_frame_serializer with a
// CRC-8 (poly 0x07, init 0x00) generator model closing the crc_in loop.
module tb_crc_frame_serializer;

    logic       clk;
    logic       reset;

    logic       in_valid, in_last, in_ready;
    logic [7:0] in_data;
    logic       tx_valid, tx_bit, tx_last, tx_ready;
    logic       crc_clear, crc_data_valid, crc_data_bit;
    logic [7:0] crc_a;

    logic       b_in_valid, b_in_last, b_in_ready;
    logic [7:0] b_in_data;
    logic       b_tx_valid, b_tx_bit, b_tx_last, b_tx_ready;
    logic       b_crc_clear, b_crc_data_valid, b_crc_data_bit;
    logic [7:0] crc_b;

    int unsigned checks = 0;
    int unsigned errors = 0;

    int unsigned cyc = 0;
    bit          bits_a[$];
    bit          bits_b[$];
    int unsigned last_cnt = 0, last_cyc = 0, clr_cnt = 0;
    int unsigned stall_bad = 0, dbit_bad = 0, rdy_shift_cnt = 0;
    int unsigned b_last_cnt = 0;
    int unsigned hs_cyc = 0;
    logic        hs_clr = 1'b0;

    crc_frame_serializer #(.DATA_W(8), .CRC_W(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_last(tx_last), .tx_ready(tx_ready),
        .crc_clear(crc_clear), .crc_data_valid(crc_data_valid),
        .crc_data_bit(crc_data_bit), .crc_in(crc_a)
    );

    crc_frame_serializer #(.DATA_W(8), .CRC_W(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last), .in_ready(b_in_ready),
        .tx_valid(b_tx_valid), .tx_bit(b_tx_bit), .tx_last(b_tx_last), .tx_ready(b_tx_ready),
        .crc_clear(b_crc_clear), .crc_data_valid(b_crc_data_valid),
        .crc_data_bit(b_crc_data_bit), .crc_in(crc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial CRC-8 generator models with registered outputs
    always_ff @(posedge clk) begin
        if (reset || crc_clear) crc_a <= 8'h00;
        else if (crc_data_valid)
            crc_a <= {crc_a[6:0], 1'b0} ^ (((crc_a[7] ^ crc_data_bit) != 1'b0) ? 8'h07 : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset || b_crc_clear) crc_b <= 8'h00;
        else if (b_crc_data_valid)
            crc_b <= {crc_b[6:0], 1'b0} ^ (((crc_b[7] ^ b_crc_data_bit) != 1'b0) ? 8'h07 : 8'h00);
    end

    // Stream monitor: records accepted bits and running protocol statistics
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid && tx_ready) begin
                bits_a.push_back(tx_bit);
                if (tx_last) begin
                    last_cnt = last_cnt + 1;
                    last_cyc = cyc;
                end
            end
            if (crc_clear) clr_cnt = clr_cnt + 1;
            if (crc_data_valid && !tx_ready) stall_bad = stall_bad + 1;
            if (crc_data_bit !== tx_bit) dbit_bad = dbit_bad + 1;
            if (in_ready && tx_valid) rdy_shift_cnt = rdy_shift_cnt + 1;
            if (b_tx_valid && b_tx_ready) begin
                bits_b.push_back(b_tx_bit);
                if (b_tx_last) b_last_cnt = b_last_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input int unsigned idx);
        logic [7:0] v;
        v = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (idx + i < $unsigned(bits_a.size())) v = {v[6:0], bits_a[idx+i]};
            else v = {v[6:0], 1'bx};
        end
        return v;
    endfunction

    function automatic logic [7:0] get_byte_b(input int unsigned idx);
        logic [7:0] v;
        v = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (idx + i < $unsigned(bits_b.size())) v = {v[6:0], bits_b[idx+i]};
            else v = {v[6:0], 1'bx};
        end
        return v;
    endfunction

    task automatic send_word(input logic [7:0] d, input logic l);
        bit          hs;
        int unsigned n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            if (in_ready) begin
                hs     = 1'b1;
                hs_cyc = cyc;
                hs_clr = crc_clear;
            end
            @(posedge clk); #1;
            n++;
        end
        check("in_handshake", 32'(hs), 32'd1);
        if (l) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_last(input int unsigned base);
        int unsigned n;
        n = 0;
        while (last_cnt == base && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("tx_last_seen", last_cnt - base, 32'd1);
    endtask

    task automatic wait_gap();
        int unsigned n;
        n = 0;
        while (tx_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_crc_gap", 32'(tx_valid), 32'd0);
        check("wait_crc_no_dv", 32'(crc_data_valid), 32'd0);
    endtask

    initial begin
        int unsigned base, clr0, lbase, rdy0, first_hs, n;
        bit          hs;

        reset = 1'b1;
        in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b1; tx_ready = 1'b1;
        b_in_valid = 1'b1; b_in_data = 8'h5A; b_in_last = 1'b1; b_tx_ready = 1'b1;

        // Reset: every output low even with in_valid asserted
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs_a", 32'({in_ready, tx_valid, tx_bit, tx_last, crc_clear, crc_data_valid}), 32'd0);
        check("rst_outs_b", 32'({b_in_ready, b_tx_valid, b_tx_last, b_crc_clear, b_crc_data_valid}), 32'd0);
        in_valid = 1'b0; in_last = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_tx_valid", 32'(tx_valid), 32'd0);

        // Single word 0x01 -> CRC 0x07, 17-cycle span
        base = bits_a.size(); lbase = last_cnt; clr0 = clr_cnt;
        send_word(8'h01, 1'b1);
        first_hs = hs_cyc;
        wait_last(lbase);
        check("w01_data", 32'(get_byte(base)), 32'h01);
        check("w01_crc", 32'(get_byte(base + 8)), 32'h07);
        check("w01_nbits", bits_a.size() - base, 32'd16);
        check("w01_span", last_cyc - first_hs, 32'd17);
        check("w01_clr", clr_cnt - clr0, 32'd1);

        // Single word 0x80 -> CRC 0x89, clear on the handshake cycle
        base = bits_a.size(); lbase = last_cnt; clr0 = clr_cnt;
        send_word(8'h80, 1'b1);
        check("w80_clr_on_hs", 32'(hs_clr), 32'd1);
        wait_last(lbase);
        check("w80_data", 32'(get_byte(base)), 32'h80);
        check("w80_crc", 32'(get_byte(base + 8)), 32'h89);
        check("w80_clr_once", clr_cnt - clr0, 32'd1);

        // "123456789" back to back -> CRC 0xF4, no gaps, no extra clears
        base = bits_a.size(); lbase = last_cnt; clr0 = clr_cnt; rdy0 = rdy_shift_cnt;
        first_hs = 0;
        for (int unsigned i = 0; i < 9; i++) begin
            send_word(8'h31 + 8'(i), (i == 8));
            if (i == 0) first_hs = hs_cyc;
        end
        wait_last(lbase);
        for (int unsigned i = 0; i < 9; i++)
            check("chk_data", 32'(get_byte(base + 8 * i)), 32'h31 + i);
        check("chk_crc", 32'(get_byte(base + 72)), 32'hF4);
        check("chk_span", last_cyc - first_hs, 32'd81);
        check("chk_clr", clr_cnt - clr0, 32'd1);
        check("chk_refill_ready", rdy_shift_cnt - rdy0, 32'd8);

        // Backpressure on the final data bit and on CRC bit 5
        base = bits_a.size(); lbase = last_cnt;
        send_word(8'h01, 1'b1);
        repeat (7) begin @(posedge clk); #1; end
        tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_d_bit", 32'(tx_bit), 32'd1);
            check("stall_d_valid", 32'(tx_valid), 32'd1);
            check("stall_d_dv", 32'(crc_data_valid), 32'd0);
            check("stall_d_inrdy", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        wait_gap();
        @(posedge clk); #1;
        repeat (5) begin @(posedge clk); #1; end
        tx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_c_bit", 32'(tx_bit), 32'd1);
            check("stall_c_dv", 32'(crc_data_valid), 32'd0);
            check("stall_c_last", 32'(tx_last), 32'd0);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        wait_last(lbase);
        check("stall_data", 32'(get_byte(base)), 32'h01);
        check("stall_crc", 32'(get_byte(base + 8)), 32'h07);
        check("stall_nbits", bits_a.size() - base, 32'd16);

        // Reset during CRC bit 3 abandons the frame
        lbase = last_cnt;
        send_word(8'h01, 1'b1);
        @(posedge clk); #1;
        wait_gap();
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        check("abort_outs", 32'({in_ready, tx_valid, tx_bit, tx_last, crc_clear, crc_data_valid}), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_no_last", last_cnt - lbase, 32'd0);
        base = bits_a.size(); clr0 = clr_cnt;
        send_word(8'h80, 1'b1);
        check("abort_clr_on_hs", 32'(hs_clr), 32'd1);
        wait_last(lbase);
        check("abort_clr", clr_cnt - clr0, 32'd1);
        check("abort_data", 32'(get_byte(base)), 32'h80);
        check("abort_crc", 32'(get_byte(base + 8)), 32'h89);

        // LSB-first instance: 0x01 goes out as 1000_0000, CRC 0x89
        b_in_valid = 1'b1; b_in_data = 8'h01; b_in_last = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 100) begin
            @(negedge clk);
            if (b_in_ready) hs = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        check("lsb_handshake", 32'(hs), 32'd1);
        b_in_valid = 1'b0; b_in_last = 1'b0;
        n = 0;
        while (b_last_cnt == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("lsb_last_seen", b_last_cnt, 32'd1);
        check("lsb_data", 32'(get_byte_b(0)), 32'h80);
        check("lsb_crc", 32'(get_byte_b(8)), 32'h89);
        check("lsb_nbits", bits_b.size(), 32'd16);

        // Invariants gathered across the whole run
        check("inv_dv_stall", stall_bad, 32'd0);
        check("inv_dbit_eq", dbit_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
